// File: rtl/board_pkg.sv
// Shared definitions for the board-processing stages: state encodings,
// count-board value constants and coordinate width helpers.
package board_pkg;

  typedef enum logic [3:0] {
    ST_INIT  = 4'b0001,
    ST_SCAN  = 4'b0010,
    ST_WRITE = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  localparam int COUNT_WIDTH = 4;
  localparam logic [COUNT_WIDTH-1:0] MINE_MARKER = 4'd9;

  localparam int K_WIDTH = 4;
  localparam logic [K_WIDTH-1:0] K_CENTRE = 4'd4;
  localparam logic [K_WIDTH-1:0] K_LAST   = 4'd8;

  // A single-column or single-row board still needs a one-bit coordinate.
  function automatic int coord_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neighbor_counter_if.sv
// Handshake, mine-board read and count-board write signals of the neighbour counter.
interface neighbor_counter_if
  import board_pkg::*;
#(
  parameter int XW = 3,
  parameter int YW = 3
);
  logic                   start;
  logic                   ack;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic                   mineBoardReadValue;
  logic                   countWriteEn;
  logic [XW-1:0]          countX;
  logic [YW-1:0]          countY;
  logic [COUNT_WIDTH-1:0] countValue;
  logic                   done;

  modport master (
    output start, ack, mineBoardReadValue,
    input  x, y, countWriteEn, countX, countY, countValue, done
  );

  modport slave (
    input  start, ack, mineBoardReadValue,
    output x, y, countWriteEn, countX, countY, countValue, done
  );
endinterface

// File: rtl/neighbor_offset_decoder.sv
// Maps scan offset k (0..8, row-major 3x3 window) around cell (cx,cy) to a
// mine-board read address; off-board offsets keep the cell's own address.
module neighbor_offset_decoder
  import board_pkg::*;
#(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8,
  localparam int XW = coord_width(boardWidth),
  localparam int YW = coord_width(boardHeight)
) (
  input  logic [K_WIDTH-1:0] k_i,
  input  logic [XW-1:0]      cx_i,
  input  logic [YW-1:0]      cy_i,
  output logic [XW-1:0]      x_o,
  output logic [YW-1:0]      y_o,
  output logic               in_bounds_o,
  output logic               is_centre_o
);
  // 2'd0 = -1, 2'd1 = 0, 2'd2 = +1
  logic [1:0] col_sel, row_sel;
  logic       k_valid;
  logic       col_lo, col_hi, row_lo, row_hi;

  always_comb begin
    col_sel = 2'd1;
    row_sel = 2'd1;
    k_valid = 1'b1;
    case (k_i)
      4'd0:    begin row_sel = 2'd0; col_sel = 2'd0; end
      4'd1:    begin row_sel = 2'd0; col_sel = 2'd1; end
      4'd2:    begin row_sel = 2'd0; col_sel = 2'd2; end
      4'd3:    begin row_sel = 2'd1; col_sel = 2'd0; end
      4'd4:    begin row_sel = 2'd1; col_sel = 2'd1; end
      4'd5:    begin row_sel = 2'd1; col_sel = 2'd2; end
      4'd6:    begin row_sel = 2'd2; col_sel = 2'd0; end
      4'd7:    begin row_sel = 2'd2; col_sel = 2'd1; end
      4'd8:    begin row_sel = 2'd2; col_sel = 2'd2; end
      default: k_valid = 1'b0;
    endcase
  end

  assign col_lo = (col_sel == 2'd0) && (cx_i == {XW{1'b0}});
  assign col_hi = (col_sel == 2'd2) && (cx_i == XW'(boardWidth - 1));
  assign row_lo = (row_sel == 2'd0) && (cy_i == {YW{1'b0}});
  assign row_hi = (row_sel == 2'd2) && (cy_i == YW'(boardHeight - 1));

  assign in_bounds_o = k_valid && !(col_lo || col_hi || row_lo || row_hi);
  assign is_centre_o = (k_i == K_CENTRE);

  always_comb begin
    x_o = cx_i;
    y_o = cy_i;
    if (in_bounds_o) begin
      case (col_sel)
        2'd0:    x_o = cx_i - XW'(1);
        2'd2:    x_o = cx_i + XW'(1);
        default: x_o = cx_i;
      endcase
      case (row_sel)
        2'd0:    y_o = cy_i - YW'(1);
        2'd2:    y_o = cy_i + YW'(1);
        default: y_o = cy_i;
      endcase
    end else begin
      x_o = cx_i;
      y_o = cy_i;
    end
  end

endmodule

// File: rtl/neighbor_counter.sv
// Scans the mine board cell by cell (9 reads each) and writes each cell's
// neighbour-mine count to the count board. MINE_MARK_EN: mine cells write 9.
module neighbor_counter
  import board_pkg::*;
#(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8
) (
  input  logic              clk,
  input  logic              reset,
  neighbor_counter_if.slave bus
);
  localparam int XW = coord_width(boardWidth);
  localparam int YW = coord_width(boardHeight);

  state_e                 state_q, state_d;
  logic [XW-1:0]          cx_q, cx_d, count_x_q, count_x_d;
  logic [YW-1:0]          cy_q, cy_d, count_y_q, count_y_d;
  logic [K_WIDTH-1:0]     k_q, k_d;
  logic [COUNT_WIDTH-1:0] acc_q, acc_d, count_val_q, count_val_d;
  logic                   mine_flag_q, mine_flag_d;
  logic                   count_we_q, count_we_d;
  logic                   in_bounds, is_centre, last_col, last_row;
  logic [XW-1:0]          rd_x;
  logic [YW-1:0]          rd_y;

  neighbor_offset_decoder #(
    .boardWidth (boardWidth),
    .boardHeight(boardHeight)
  ) u_offset (
    .k_i        (k_q),
    .cx_i       (cx_q),
    .cy_i       (cy_q),
    .x_o        (rd_x),
    .y_o        (rd_y),
    .in_bounds_o(in_bounds),
    .is_centre_o(is_centre)
  );

  assign last_col = (cx_q == XW'(boardWidth - 1));
  assign last_row = (cy_q == YW'(boardHeight - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = bus.start ? ST_SCAN : ST_INIT;
      ST_SCAN:  state_d = (k_q == K_LAST) ? ST_WRITE : ST_SCAN;
      ST_WRITE: state_d = (last_col && last_row) ? ST_DONE : ST_SCAN;
      ST_DONE:  state_d = bus.ack ? ST_INIT : ST_DONE;
      default:  state_d = ST_INIT;
    endcase
  end

  // Datapath next values: cell/offset counters, accumulator, write registers
  always_comb begin
    cx_d        = cx_q;
    cy_d        = cy_q;
    k_d         = k_q;
    acc_d       = acc_q;
    mine_flag_d = mine_flag_q;
    count_we_d  = 1'b0;
    count_x_d   = count_x_q;
    count_y_d   = count_y_q;
    count_val_d = count_val_q;
    case (state_q)
      ST_INIT: begin
        if (bus.start) begin
          cx_d        = '0;
          cy_d        = '0;
          k_d         = '0;
          acc_d       = '0;
          mine_flag_d = 1'b0;
        end else begin
          cx_d = cx_q;
        end
      end
      ST_SCAN: begin
        if (!is_centre && in_bounds && bus.mineBoardReadValue) acc_d = acc_q + 4'd1;
        else                                                   acc_d = acc_q;
        if (is_centre) mine_flag_d = bus.mineBoardReadValue;
        else           mine_flag_d = mine_flag_q;
        // acc_d already includes the k=8 read, so the write value is final here.
        if (k_q == K_LAST) begin
          count_we_d = 1'b1;
          count_x_d  = cx_q;
          count_y_d  = cy_q;
`ifdef MINE_MARK_EN
          count_val_d = mine_flag_q ? MINE_MARKER : acc_d;
`else
          count_val_d = acc_d;
`endif
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_WRITE: begin
        acc_d       = '0;
        k_d         = '0;
        mine_flag_d = 1'b0;
        if (last_col) begin
          cx_d = '0;
          cy_d = cy_q + YW'(1);
        end else begin
          cx_d = cx_q + XW'(1);
        end
      end
      ST_DONE: cx_d = cx_q;
      default: cx_d = cx_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx_q        <= '0;
      cy_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      mine_flag_q <= 1'b0;
      count_we_q  <= 1'b0;
      count_x_q   <= '0;
      count_y_q   <= '0;
      count_val_q <= '0;
    end else begin
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      mine_flag_q <= mine_flag_d;
      count_we_q  <= count_we_d;
      count_x_q   <= count_x_d;
      count_y_q   <= count_y_d;
      count_val_q <= count_val_d;
    end
  end

  // Output logic
  always_comb begin
    bus.done = 1'b0;
    case (state_q)
      ST_DONE: bus.done = 1'b1;
      default: bus.done = 1'b0;
    endcase
  end

  assign bus.x            = rd_x;
  assign bus.y            = rd_y;
  assign bus.countWriteEn = count_we_q;
  assign bus.countX       = count_x_q;
  assign bus.countY       = count_y_q;
  assign bus.countValue   = count_val_q;

endmodule

// File: tb/tb_neighbor_counter.sv
// Randomised and directed boards checked against a neighbourhood-sum reference model.
module tb_neighbor_counter;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int NCELL = W * H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  neighbor_counter_if #(.XW(3), .YW(3)) bus();

  bit mines [0:H-1][0:W-1];
  assign bus.mineBoardReadValue = mines[bus.y][bus.x];

  neighbor_counter #(.boardWidth(W), .boardHeight(H)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int wr_pos[$];
  int wr_val[$];

  always @(negedge clk) begin
    if (bus.countWriteEn === 1'b1) begin
      wr_pos.push_back(int'(bus.countY) * W + int'(bus.countX));
      wr_val.push_back(int'(bus.countValue));
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input int cx, input int cy);
    int n = 0;
`ifdef MINE_MARK_EN
    if (mines[cy][cx]) return 9;
`endif
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int nx = cx + dx;
        int ny = cy + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < W && ny >= 0 && ny < H)
          n += int'(mines[ny][nx]);
      end
    return n;
  endfunction

  task automatic fill_board(input int pct);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        mines[yy][xx] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic start_and_wait(output int cycles);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_board(input string name, input bit hold_test);
    int cyc;
    int n0;
    wr_pos.delete();
    wr_val.delete();
    start_and_wait(cyc);
    check_val({name, ":latency"}, cyc, 10 * NCELL);
    check_val({name, ":nwrites"}, wr_pos.size(), NCELL);
    for (int i = 0; i < wr_pos.size() && i < NCELL; i++) begin
      check_val($sformatf("%s:pos%0d", name, i), wr_pos[i], i);
      check_val($sformatf("%s:val(%0d,%0d)", name, i % W, i / W), wr_val[i], ref_count(i % W, i / W));
    end
    if (hold_test) begin
      n0 = wr_pos.size();
      for (int c = 0; c < 20; c++) begin
        bus.start = (c >= 5 && c < 10);
        @(negedge clk);
        #1 check_val($sformatf("%s:hold_done%0d", name, c), bus.done, 1);
      end
      bus.start = 1'b0;
      check_val({name, ":hold_nowrite"}, wr_pos.size(), n0);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.ack = 1'b1;
    @(negedge clk) bus.ack = 1'b0;
    #1 check_val({name, ":done_drop"}, bus.done, 0);
    repeat (3) @(negedge clk);
    #1 check_val({name, ":idle_done"}, bus.done, 0);
    check_val({name, ":idle_nowrite"}, wr_pos.size(), NCELL);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    reset     = 1'b0;
    fill_board(0);
    repeat (3) @(negedge clk);
    check_val("rst:we", bus.countWriteEn, 0);
    check_val("rst:done", bus.done, 0);
    check_val("rst:cx", bus.countX, 0);
    check_val("rst:cy", bus.countY, 0);
    check_val("rst:cval", bus.countValue, 0);
    reset = 1'b1;
    @(negedge clk);

    run_board("empty", 1'b1);

    fill_board(0);
    mines[3][3] = 1'b1;
    run_board("single33", 1'b0);

    fill_board(0);
    mines[0][0] = 1'b1;
    run_board("corner00", 1'b0);

    fill_board(100);
    run_board("full", 1'b0);

    // Reset in the middle of cell 10's scan, then a clean rescan.
    fill_board(40);
    wr_pos.delete();
    wr_val.delete();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (105) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midrst:we", bus.countWriteEn, 0);
    check_val("midrst:done", bus.done, 0);
    check_val("midrst:x", bus.x, 0);
    check_val("midrst:y", bus.y, 0);
    check_val("midrst:partial", wr_pos.size(), 10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1 check_val("midrst:idle_done", bus.done, 0);
    check_val("midrst:idle_nowrite", wr_pos.size(), 10);
    run_board("restart", 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_board($urandom_range(5, 90));
      run_board($sformatf("rand%0d", r), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neighbor_counter.md
Name: neighbor_counter

Overview:
- Downstream stage of mine placement.
- Starts once the mine board is fully populated. Scans every cell in row-major order and counts mines in the 8-neighbourhood. Writes one count per cell into the count board.
- The game and display logic read the count board afterwards.
- Uses the same start/ack/done handshake as the other board-processing stages.

Parameters:
boardWidth, 8, board columns (power of 2, >=2)
boardHeight, 8, board rows (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin scan; sampled only in INIT
ack  input  1  acknowledge completion; sampled only in DONE
x  output  $clog2(boardWidth)  mine-board read column (combinational from internal registers)
y  output  $clog2(boardHeight)  mine-board read row
mineBoardReadValue  input  1  mine bit at (x,y); combinational read, valid same cycle
countWriteEn  output  1  count-board write strobe, one cycle per cell
countX  output  $clog2(boardWidth)  write column
countY  output  $clog2(boardHeight)  write row
countValue  output  4  value written
done  output  1  high exactly while in DONE

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset (reset=0) forces state=INIT and zeroes all registered outputs and internal registers immediately: countWriteEn, countX, countY, countValue, cell counters cx/cy, offset counter k, accumulator.
- States, one-hot 4 bits: INIT=0001, SCAN=0010, WRITE=0100, DONE=1000.
- INIT:
  - If start=1: cx=cy=0, k=0, acc=0, mineFlag=0, go to SCAN.
  - Otherwise hold.
  - countWriteEn=0.
- SCAN (9 cycles per cell, k=0..8):
  - Offset: dx=(k%3)-1, dy=(k/3)-1. k=4 is the centre cell.
  - inBounds=0 when (dx=-1 and cx=0), (dx=+1 and cx=W-1), (dy=-1 and cy=0), or (dy=+1 and cy=H-1).
  - When inBounds: x=cx+dx, y=cy+dy.
  - When out of bounds: x=cx, y=cy. The read is ignored; there is no wrap-around.
  - At the clock edge:
    - k!=4, inBounds, mineBoardReadValue=1: acc += 1.
    - k=4: mineFlag <= mineBoardReadValue.
    - k=8: go to WRITE; otherwise k++.
  - Out-of-bounds cycles still consume a cycle, so latency is fixed.
  - acc is 4 bits; maximum value 8; no overflow possible.
- WRITE (1 cycle):
  - Registered outputs hold for this cycle: countWriteEn=1, countX=cx, countY=cy, countValue=acc (see Optional Feature).
  - At the edge: countWriteEn cleared; acc, k, mineFlag cleared.
  - If cx=W-1 and cy=H-1: go to DONE.
  - Else if cx=W-1: cx=0, cy++, go to SCAN.
  - Else: cx++, go to SCAN.
- DONE:
  - done=1.
  - If ack=1: go to INIT. done drops the cycle after ack is sampled.
  - start is ignored.
- Latency: start sampled at edge E -> DONE entered at edge E+10*W*H (E+640 at 8x8).
  - Exactly W*H countWriteEn pulses, one per cell, in row-major order.
- Signals ignored outside their states: start outside INIT; ack outside DONE.
- Reset mid-operation: countWriteEn drops asynchronously and the partial count board is abandoned. A new start rescans all cells.

Optional Feature:
MINE_MARK_EN
- Defined: a cell with mineFlag=1 writes countValue=4'd9 (mine marker) instead of acc.
- Undefined: every cell writes acc regardless of mineFlag. The k=4 read still occurs but its result is unused.
- Latency is identical either way.

Decomposition:
- Shared package (board_pkg):
  - state encodings INIT/SCAN/WRITE/DONE
  - MINE_MARKER=4'd9
  - COUNT_WIDTH=4
  - helper width constants for boardWidth/boardHeight coordinates
- One natural sub-module: neighbor_offset_decoder.
  - Combinational mapping (k, cx, cy) -> (x, y, inBounds, isCentre).
  - Parameterised by boardWidth/boardHeight.
  - Unit-testable exhaustively.

Test Plan:
- Empty board, pulse start: 64 writes, all countValue=0, row-major order; done rises exactly 640 cycles after the start edge.
- Single mine at (3,3): cells (2..4,2..4) except (3,3) write 1; (3,3) writes 0, or 9 with MINE_MARK_EN; all other cells write 0.
- Mine at corner (0,0): (1,0), (0,1), (1,1) write 1. Assert x,y never address off-board and that no wrap credits (7,x) or (x,7).
- Full board of 64 mines, feature off: corner cells write 3, non-corner edge cells write 5, interior cells write 8. Feature on: all cells write 9.
- Assert reset=0 at E+105 (mid-SCAN of cell 10): countWriteEn is 0 immediately, state is INIT; a restart produces the full 64-write sequence correctly.
- Handshake: hold ack=0 for 20 cycles in DONE -> done stays 1 and no writes occur. Assert start in DONE -> ignored. Pulse ack -> INIT, done=0 next cycle.
